i2c_eeprom_ptr_ctrl: RTL and testbench
======================================

Name: i2c_eeprom_ptr_ctrl

Overview:
- Sits inside i2c_slave_top, between the I2C slave byte engine (bus side) and the ROM (rom_mem).
- Turns byte-level bus events into an EEPROM access model: a 2-byte address write loads a 16-bit pointer, and read transactions stream ROM bytes from that pointer with auto-increment.
- Writes beyond the address bytes are NACKed; the memory is read-only.

Parameters:
- ADDR_W, 16, pointer and ROM address width; the pointer wraps modulo 2^ADDR_W.
- ROM_LATENCY, 1, cycles from out_rom_rd_en to valid in_rom_data; legal values 1..4.

Ports:
- in_ext_osc  input  1  system clock.
- in_reset_n  input  1  asynchronous active-low reset.
- in_start  input  1  one-cycle pulse on START or repeated START.
- in_stop  input  1  one-cycle pulse on STOP.
- in_addr_hit  input  1  one-cycle pulse: own 7-bit address matched.
- in_rw  input  1  R/W bit, valid with in_addr_hit (1 = read).
- in_wr_valid  input  1  one-cycle pulse: data byte received from master.
- in_wr_byte  input  8  received byte, valid with in_wr_valid.
- in_rd_req  input  1  one-cycle pulse: engine needs next byte to shift out.
- in_master_nack  input  1  one-cycle pulse: master NACKed the last read byte.
- out_wr_ack  output  1  level: 1 = ACK the byte just received; sampled by engine 1 cycle after in_wr_valid.
- out_rd_valid  output  1  one-cycle pulse: out_rd_byte holds the requested byte.
- out_rd_byte  output  8  byte to transmit; held until next out_rd_valid.
- out_rom_addr  output  ADDR_W  ROM read address.
- out_rom_rd_en  output  1  one-cycle ROM read strobe.
- in_rom_data  input  8  ROM read data, valid ROM_LATENCY cycles after strobe.
- out_busy  output  1  1 while state != IDLE.

Behaviour:
Reset values (async, in_reset_n low):
- state = IDLE; pointer = 0.
- out_wr_ack = 0, out_rd_valid = 0, out_rd_byte = 8'hFF, out_rom_addr = 0, out_rom_rd_en = 0, out_busy = 0.

States: IDLE, ADDR_HI, ADDR_LO, WR_DATA, RD_IDLE, RD_FETCH, RD_WAIT.
- IDLE:
  - in_addr_hit & !in_rw -> ADDR_HI.
  - in_addr_hit & in_rw -> RD_IDLE.
- ADDR_HI: in_wr_valid -> latch pointer[15:8], out_wr_ack = 1, -> ADDR_LO.
- ADDR_LO: in_wr_valid -> latch pointer[7:0], out_wr_ack = 1, -> WR_DATA.
- WR_DATA: in_wr_valid -> out_wr_ack = 0 (NACK); pointer unchanged; state stays.
- RD_IDLE: in_rd_req -> assert out_rom_rd_en for 1 cycle with out_rom_addr = pointer, -> RD_FETCH.
- RD_FETCH/RD_WAIT: count ROM_LATENCY cycles. On the cycle in_rom_data is valid:
  - register it into out_rd_byte;
  - pulse out_rd_valid the next cycle;
  - pointer <= pointer + 1 (wraps 0xFFFF -> 0x0000);
  - -> RD_IDLE.
- Latency: in_rd_req to out_rd_valid = ROM_LATENCY + 2 cycles, fixed.
- in_master_nack: no effect on the pointer (the byte was already counted); -> IDLE.
- in_stop in any state: -> IDLE, same cycle priority over all other inputs; pointer retained.
- in_start in any state: -> IDLE; pointer retained, so the write-address-then-repeated-START-read flow works.
- An address write with only the high byte received before STOP/START: pointer[15:8] updated, pointer[7:0] keeps its old value.
- in_rd_req while RD_FETCH/RD_WAIT: protocol error; ignored, no second ROM strobe.
- in_wr_valid while in a read state, or in_rd_req while in a write state: ignored.
- In IDLE, out_wr_ack = 0, so non-matching traffic is never ACKed here.
- ROM strobe aborted by STOP mid-fetch: returning data is discarded; no out_rd_valid; pointer not incremented.
- Reset mid-operation: immediate return to reset values; no ROM strobe is issued after reset assertion.

Test Plan:
- Write 0x00,0x01, then read 4 -> ACK on both address bytes; ROM addresses 0x0001..0x0004 strobed in order; bytes equal mem[1..4]; pointer = 0x0005.
- Write 0xAA,0xCC, repeated START, read 8 -> bytes equal mem[0xAACC..0xAAD3]; each out_rd_valid exactly ROM_LATENCY+2 cycles after in_rd_req (check ROM_LATENCY = 1 and 3).
- Set pointer to 0xFFFE, read 4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; final pointer = 0x0002.
- Write 0x12,0x34,0x56 -> ACK, ACK, NACK on the third byte; subsequent read of 1 returns mem[0x1234].
- Read 2 without a prior address write after reset -> returns mem[0], mem[1]; master NACK on the second byte -> IDLE, out_busy = 0.
- STOP injected 1 cycle after out_rom_rd_en -> no out_rd_valid, pointer unchanged. Separately, assert in_reset_n low during RD_WAIT -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/i2c_eeprom_ptr_ctrl.sv
// EEPROM-style pointer controller between the I2C slave byte engine and rom_mem:
// a two-byte address write loads the pointer, reads stream ROM bytes with auto-increment.
module i2c_eeprom_ptr_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic              in_ext_osc,
  input  logic              in_reset_n,
  input  logic              in_start,
  input  logic              in_stop,
  input  logic              in_addr_hit,
  input  logic              in_rw,
  input  logic              in_wr_valid,
  input  logic [7:0]        in_wr_byte,
  input  logic              in_rd_req,
  input  logic              in_master_nack,
  output logic              out_wr_ack,
  output logic              out_rd_valid,
  output logic [7:0]        out_rd_byte,
  output logic [ADDR_W-1:0] out_rom_addr,
  output logic              out_rom_rd_en,
  input  logic [7:0]        in_rom_data,
  output logic              out_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WR_DATA,
    ST_RD_IDLE,
    ST_RD_FETCH,
    ST_RD_WAIT
  } state_t;

  // Edges after the strobe edge at which in_rom_data is sampled.
  localparam logic [2:0] LAT = 3'(ROM_LATENCY);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [2:0]        wait_cnt;

  assign out_busy = (state != ST_IDLE);

  always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      wait_cnt      <= '0;
      out_wr_ack    <= 1'b0;
      out_rd_valid  <= 1'b0;
      out_rd_byte   <= 8'hFF;
      out_rom_addr  <= '0;
      out_rom_rd_en <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; only the branch that fires raises them.
      out_rd_valid  <= 1'b0;
      out_rom_rd_en <= 1'b0;

      if (in_stop || in_start) begin
        // Bus framing wins over everything; the pointer survives for repeated-START reads.
        state      <= ST_IDLE;
        out_wr_ack <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            out_wr_ack <= 1'b0;
            if (in_addr_hit) state <= in_rw ? ST_RD_IDLE : ST_ADDR_HI;
          end

          ST_ADDR_HI: begin
            if (in_wr_valid) begin
              ptr[15:8]  <= in_wr_byte;
              out_wr_ack <= 1'b1;
              state      <= ST_ADDR_LO;
            end
          end

          ST_ADDR_LO: begin
            if (in_wr_valid) begin
              ptr[7:0]   <= in_wr_byte;
              out_wr_ack <= 1'b1;
              state      <= ST_WR_DATA;
            end
          end

          ST_WR_DATA: begin
            if (in_wr_valid) out_wr_ack <= 1'b0;
          end

          ST_RD_IDLE: begin
            if (in_master_nack) begin
              state <= ST_IDLE;
            end else if (in_rd_req) begin
              out_rom_rd_en <= 1'b1;
              out_rom_addr  <= ptr;
              wait_cnt      <= '0;
              state         <= ST_RD_FETCH;
            end
          end

          ST_RD_FETCH, ST_RD_WAIT: begin
            // Further read requests are ignored here so only one strobe is in flight.
            if (in_master_nack) begin
              state <= ST_IDLE;
            end else if (wait_cnt == LAT) begin
              out_rd_byte  <= in_rom_data;
              out_rd_valid <= 1'b1;
              ptr          <= ptr + ADDR_W'(1);
              state        <= ST_RD_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 3'd1;
              state    <= ST_RD_WAIT;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_ptr_ctrl.sv
// Directed bench for i2c_eeprom_ptr_ctrl: two instances (ROM latency 1 and 3) share
// the same bus stimulus, each backed by a small pipelined ROM model.
module tb_i2c_eeprom_ptr_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start, stop, addr_hit, rw, wr_valid, rd_req, master_nack;
  logic [7:0] wr_byte;

  logic [1:0]       wr_ack, rd_valid, rom_rd_en, busy;
  logic [1:0][7:0]  rd_byte, rom_data;
  logic [1:0][15:0] rom_addr;

  logic [7:0] pipe [2][4];
  int         strobe_cnt [2] = '{0, 0};

  logic [15:0] ptr_exp;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    i2c_eeprom_ptr_ctrl #(.ADDR_W(16), .ROM_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .in_ext_osc    (clk),
      .in_reset_n    (rst_n),
      .in_start      (start),
      .in_stop       (stop),
      .in_addr_hit   (addr_hit),
      .in_rw         (rw),
      .in_wr_valid   (wr_valid),
      .in_wr_byte    (wr_byte),
      .in_rd_req     (rd_req),
      .in_master_nack(master_nack),
      .out_wr_ack    (wr_ack[g]),
      .out_rd_valid  (rd_valid[g]),
      .out_rd_byte   (rd_byte[g]),
      .out_rom_addr  (rom_addr[g]),
      .out_rom_rd_en (rom_rd_en[g]),
      .in_rom_data   (rom_data[g]),
      .out_busy      (busy[g])
    );
  end

  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // ROM model: data appears `lat` cycles after the strobe, for one cycle only.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= rom_rd_en[g] ? rom_fn(rom_addr[g]) : 8'hEE;
      for (int i = 1; i < 4; i++) pipe[g][i] <= pipe[g][i-1];
      if (rom_rd_en[g]) strobe_cnt[g] <= strobe_cnt[g] + 1;
    end
  end
  assign rom_data[0] = pipe[0][0];
  assign rom_data[1] = pipe[1][2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [1:0] act, input logic exp);
    for (int g = 0; g < 2; g++)
      check($sformatf("%s_l%0d", tag, lat(g)), 32'(act[g]), 32'(exp));
  endtask

  task automatic check_ptr(input string tag);
    check({tag, "_ptr_l1"}, 32'(g_dut[0].u_dut.ptr), 32'(ptr_exp));
    check({tag, "_ptr_l3"}, 32'(g_dut[1].u_dut.ptr), 32'(ptr_exp));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop(input string tag);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    check_both({tag, "_stop_busy"}, busy, 1'b0);
    check_both({tag, "_stop_ack"}, wr_ack, 1'b0);
  endtask

  task automatic open_xfer(input logic is_rd, input string tag);
    pulse_start();
    @(negedge clk) begin addr_hit = 1'b1; rw = is_rd; end
    @(negedge clk) addr_hit = 1'b0;
    check_both({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    @(negedge clk) begin wr_valid = 1'b1; wr_byte = b; end
    @(negedge clk) wr_valid = 1'b0;
    check_both(tag, wr_ack, exp_ack);
  endtask

  task automatic master_nack_pulse(input string tag);
    @(negedge clk) master_nack = 1'b1;
    @(negedge clk) master_nack = 1'b0;
    check_both({tag, "_nack_busy"}, busy, 1'b0);
  endtask

  // Issues one read request; checks strobe/address, latency, pulse count and data.
  task automatic read_byte(input string tag);
    logic [15:0] a;
    int seen_at [2];
    int pulses [2];
    logic [7:0] got [2];
    a = ptr_exp;
    seen_at = '{0, 0};
    pulses = '{0, 0};
    got = '{8'h00, 8'h00};
    @(negedge clk) rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_strobe_l%0d", tag, lat(g)), 32'(rom_rd_en[g]), 32'd1);
      check($sformatf("%s_addr_l%0d", tag, lat(g)), 32'(rom_addr[g]), 32'(a));
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        if (rd_valid[g]) begin
          pulses[g]++;
          seen_at[g] = k + 1;
          got[g] = rd_byte[g];
        end
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_lat_l%0d", tag, lat(g)), 32'(seen_at[g]), 32'(lat(g) + 2));
      check($sformatf("%s_pulses_l%0d", tag, lat(g)), 32'(pulses[g]), 32'd1);
      check($sformatf("%s_data_l%0d", tag, lat(g)), 32'(got[g]), 32'(rom_fn(a)));
    end
    ptr_exp = a + 16'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_wr_ack_l%0d", tag, lat(g)), 32'(wr_ack[g]), 32'd0);
      check($sformatf("%s_rd_valid_l%0d", tag, lat(g)), 32'(rd_valid[g]), 32'd0);
      check($sformatf("%s_rd_byte_l%0d", tag, lat(g)), 32'(rd_byte[g]), 32'hFF);
      check($sformatf("%s_rom_addr_l%0d", tag, lat(g)), 32'(rom_addr[g]), 32'd0);
      check($sformatf("%s_rd_en_l%0d", tag, lat(g)), 32'(rom_rd_en[g]), 32'd0);
      check($sformatf("%s_busy_l%0d", tag, lat(g)), 32'(busy[g]), 32'd0);
    end
  endtask

  initial begin
    int cnt_before [2];
    int pulses [2];
    logic [7:0] last_byte;

    rst_n = 1'b0;
    {start, stop, addr_hit, rw, wr_valid, rd_req, master_nack} = '0;
    wr_byte = 8'h00;
    ptr_exp = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check_ptr("reset");
    rst_n = 1'b1;

    // Address 0x0001, then read four bytes.
    open_xfer(1'b0, "t1_w");
    write_byte(8'h00, 1'b1, "t1_ack_hi");
    write_byte(8'h01, 1'b1, "t1_ack_lo");
    pulse_stop("t1_w");
    ptr_exp = 16'h0001;
    open_xfer(1'b1, "t1_r");
    for (int i = 0; i < 4; i++) read_byte($sformatf("t1_rd%0d", i));
    check_ptr("t1_end");
    master_nack_pulse("t1");
    pulse_stop("t1_r");

    // Address 0xAACC, repeated START, read eight bytes.
    open_xfer(1'b0, "t2_w");
    write_byte(8'hAA, 1'b1, "t2_ack_hi");
    write_byte(8'hCC, 1'b1, "t2_ack_lo");
    ptr_exp = 16'hAACC;
    open_xfer(1'b1, "t2_r");
    for (int i = 0; i < 8; i++) read_byte($sformatf("t2_rd%0d", i));
    check_ptr("t2_end");
    master_nack_pulse("t2");

    // Pointer wrap from 0xFFFE.
    open_xfer(1'b0, "t3_w");
    write_byte(8'hFF, 1'b1, "t3_ack_hi");
    write_byte(8'hFE, 1'b1, "t3_ack_lo");
    pulse_stop("t3_w");
    ptr_exp = 16'hFFFE;
    open_xfer(1'b1, "t3_r");
    for (int i = 0; i < 4; i++) read_byte($sformatf("t3_rd%0d", i));
    check_ptr("t3_end");
    pulse_stop("t3_r");

    // Data byte after the address is NACKed and leaves the pointer alone.
    open_xfer(1'b0, "t4_w");
    write_byte(8'h12, 1'b1, "t4_ack_hi");
    write_byte(8'h34, 1'b1, "t4_ack_lo");
    write_byte(8'h56, 1'b0, "t4_nack_data");
    ptr_exp = 16'h1234;
    check_ptr("t4_after_data");
    pulse_stop("t4_w");
    open_xfer(1'b1, "t4_r");
    read_byte("t4_rd0");
    last_byte = rom_fn(16'h1234);
    pulse_stop("t4_r");

    // STOP one cycle after the strobe: data discarded, pointer kept.
    open_xfer(1'b1, "t6_r");
    @(negedge clk) rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    check_both("t6_strobe", rom_rd_en, 1'b1);
    @(negedge clk) stop = 1'b1;
    pulses = '{0, 0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk) stop = 1'b0;
      for (int g = 0; g < 2; g++) if (rd_valid[g]) pulses[g]++;
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t6_no_valid_l%0d", lat(g)), 32'(pulses[g]), 32'd0);
      check($sformatf("t6_byte_held_l%0d", lat(g)), 32'(rd_byte[g]), 32'(last_byte));
    end
    check_both("t6_busy", busy, 1'b0);
    check_ptr("t6_end");

    // Reset asserted while the latency-3 instance sits in RD_WAIT.
    open_xfer(1'b1, "t7_r");
    @(negedge clk) rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    cnt_before = strobe_cnt;
    #1;
    check_reset_outputs("t7_rst");
    repeat (4) @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("t7_no_strobe_l%0d", lat(g)), 32'(strobe_cnt[g]), 32'(cnt_before[g]));
    ptr_exp = 16'h0000;
    check_ptr("t7_rst");
    rst_n = 1'b1;

    // Read two bytes with no address write after reset, then master NACK.
    open_xfer(1'b1, "t5_r");
    read_byte("t5_rd0");
    read_byte("t5_rd1");
    master_nack_pulse("t5");
    check_ptr("t5_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
